spi_flash_responder: RTL and testbench

//  SPI mode-0 target that answers FAST_READ (0x0B) like a serial flash, serving bytes from an on-chip byte-read port.
//  It is the responder end of the uio[0..3] SPI link: a host, tester or a second tile running the program-memory initiator fetches code/data from it.
//  All SPI pins are oversampled in the clk domain; no SCLK-clocked flops.

---
 rtl/spi_flash_responder.sv | 261 ++++++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// -----------------------------------------------------------------------------
// spi_flash_responder
//
// SPI mode-0 target that answers FAST_READ (0x0B) like a serial flash. Bytes
// are served from an on-chip byte-read port with a one-byte prefetch buffer.
// All SPI pins are oversampled in the clk domain. There are no SCLK-clocked
// flops. f_sclk must be at most f_clk/8.
//
// Optional feature macro: SPI_RESP_STATUS_EN
//   When defined, command 0x05 (READ STATUS) streams {6'b0, underrun, mem_req}
//   every byte until cs rises.
//   When undefined, 0x05 is treated as an unknown command and is ignored.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   spi_cs          chip select, active-low, asynchronous to clk
//   spi_sclk        SPI clock, asynchronous to clk
//   spi_mosi        host->target data, MSB first
//   spi_miso        target->host data
//   spi_miso_oe     output enable for the spi_miso pad
//   mem_addr        byte address of the current fetch
//   mem_req         fetch request level
//   mem_rdata       fetched byte
//   mem_ready       one-cycle fetch-complete strobe
//   busy            high while a transaction is open (synced cs low)
//   underrun        sticky; a data byte was needed before its fetch completed
//
// Memory handshake
//   mem_req rises with mem_addr valid and holds both steady until the cycle
//   in which mem_ready=1. In that cycle mem_rdata is taken. mem_req is low in
//   the following cycle, and only then may the next request be raised.
// -----------------------------------------------------------------------------
module spi_flash_responder #(
    parameter int ADDR_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DUMMY_CYC   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_cs,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              underrun
);

    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
`ifdef SPI_RESP_STATUS_EN
    localparam logic [7:0] CMD_READ_STATUS = 8'h05;
`endif
    // Only the bits needed to assemble the command byte or the low address
    // bits are kept in the input shifter.
    localparam int SH_W = (ADDR_W > 8) ? ADDR_W - 1 : 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_IGNORE,
        ST_STATUS
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
    logic                   cs_s, sclk_s, mosi_s, sclk_prev;
    logic                   rise, fall;

    logic [7:0]        cnt;
    logic [SH_W-1:0]   shift_in;
    logic              load_due;
    logic [7:0]        shreg;
    logic [7:0]        hold;
    logic              hold_valid;
    logic              stale;      // outstanding fetch whose data is to be dropped
    logic              req_pend;   // a fetch of addr_ptr is waiting to issue
    logic [ADDR_W-1:0] addr_ptr;

    logic [7:0] cmd_byte;
    logic       addr_done, streaming, load_now, shift_now, data_load;
    logic       resp_ok, skip, issue, abort;

    // ---------------- synchronisers and edge detect ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev <= sclk_s;
        end
    end

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    // Edges while cs is high are ignored.
    assign rise   = !cs_s && sclk_s && !sclk_prev;
    assign fall   = !cs_s && !sclk_s && sclk_prev;

    assign cmd_byte = {shift_in[6:0], mosi_s};

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        addr_done  = 1'b0;
        if (cs_s) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: state_next = ST_CMD;
                ST_CMD: begin
                    if (rise && cnt == 8'd7) begin
                        if (cmd_byte == CMD_FAST_READ) state_next = ST_ADDR;
`ifdef SPI_RESP_STATUS_EN
                        else if (cmd_byte == CMD_READ_STATUS) state_next = ST_STATUS;
`endif
                        else state_next = ST_IGNORE;
                    end
                end
                ST_ADDR: begin
                    if (rise && cnt == 8'd23) begin
                        addr_done  = 1'b1;
                        state_next = (DUMMY_CYC == 0) ? ST_DATA : ST_DUMMY;
                    end
                end
                ST_DUMMY: begin
                    if (rise && cnt == 8'(DUMMY_CYC - 1)) state_next = ST_DATA;
                end
                default: state_next = state;
            endcase
        end
    end

    assign streaming = (state == ST_DATA) || (state == ST_STATUS);
    assign load_now  = streaming && fall && load_due;
    assign shift_now = streaming && fall && !load_due;
    assign data_load = load_now && (state == ST_DATA);
    assign resp_ok   = mem_req && mem_ready && !stale;
    // Underrun while the needed byte's fetch has not even issued: abandon
    // that address and move the pending fetch on to the next one.
    assign skip      = data_load && !hold_valid && !resp_ok && req_pend;
    assign issue     = !mem_req && req_pend && !skip && !cs_s;
    assign abort     = cs_s && (state != ST_IDLE);

    assign spi_miso  = shreg[7] & spi_miso_oe;

    // ---------------- state, serial and fetch datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            cnt         <= '0;
            shift_in    <= '0;
            load_due    <= 1'b0;
            shreg       <= '0;
            spi_miso_oe <= 1'b0;
            underrun    <= 1'b0;
            hold        <= '0;
            hold_valid  <= 1'b0;
            stale       <= 1'b0;
            req_pend    <= 1'b0;
            addr_ptr    <= '0;
            mem_addr    <= '0;
            mem_req     <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= !cs_s;

            // Bit counter restarts on every phase change and every 8 bits
            // while streaming.
            if (cs_s) begin
                cnt      <= '0;
                shift_in <= '0;
            end else if (rise) begin
                shift_in <= {shift_in[SH_W-2:0], mosi_s};
                if (state_next != state) cnt <= '0;
                else if (streaming && cnt == 8'd7) cnt <= '0;
                else cnt <= cnt + 8'd1;
            end

            if (state_next != state &&
                (state_next == ST_DATA || state_next == ST_STATUS)) load_due <= 1'b1;
            else if (streaming && rise && cnt == 8'd7) load_due <= 1'b1;
            else if (load_now) load_due <= 1'b0;

            if (load_now) begin
                spi_miso_oe <= 1'b1;
                if (state == ST_DATA) begin
                    if (hold_valid) shreg <= hold;
                    else if (resp_ok) shreg <= mem_rdata;
                    else begin
                        shreg    <= 8'h00;
                        underrun <= 1'b1;
                    end
                end else begin
`ifdef SPI_RESP_STATUS_EN
                    shreg <= {6'b0, underrun, mem_req};
`else
                    shreg <= 8'h00;
`endif
                end
            end else if (shift_now) begin
                shreg <= {shreg[6:0], 1'b0};
            end

            // Fetch side. Later assignments take priority.
            if (resp_ok) begin
                hold       <= mem_rdata;
                hold_valid <= 1'b1;
            end
            if (mem_req && mem_ready) begin
                mem_req <= 1'b0;
                stale   <= 1'b0;
            end
            if (issue) begin
                mem_req  <= 1'b1;
                mem_addr <= addr_ptr;
                addr_ptr <= addr_ptr + ADDR_W'(1);
                req_pend <= 1'b0;
            end
            if (addr_done) begin
                addr_ptr <= {shift_in[ADDR_W-2:0], mosi_s};
                req_pend <= 1'b1;
            end
            if (data_load) begin
                hold_valid <= 1'b0;
                if (skip) begin
                    addr_ptr <= addr_ptr + ADDR_W'(1);
                end else begin
                    req_pend <= 1'b1;
                    // The in-flight fetch was for the byte we just gave up on.
                    if (!hold_valid && !resp_ok && mem_req && !stale) stale <= 1'b1;
                end
            end

            // cs high: close the transaction and drop any in-flight data.
            if (abort) begin
                req_pend    <= 1'b0;
                hold_valid  <= 1'b0;
                stale       <= mem_req && !mem_ready;
                spi_miso_oe <= 1'b0;
                shreg       <= '0;
                load_due    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_responder
//
// Drives SPI transactions as a host. A byte-addressed memory answers mem_req
// with a configurable latency. Each transaction's expected bytes come from
// the memory array and the address/byte-index rules: byte i comes from
// (addr + i) mod 2^16, and a byte whose fetch is stalled reads as 0x00.
// -----------------------------------------------------------------------------
module tb_spi_flash_responder;

    localparam int CLK_HALF  = 5;
    localparam int SCLK_HALF = 60;
    localparam int STALL_LAT = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_cs, spi_sclk, spi_mosi;
    logic        spi_miso, spi_miso_oe;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ready = 1'b0;
    logic        busy, underrun;

    spi_flash_responder dut (
        .clk         (clk),
        .rst         (rst),
        .spi_cs      (spi_cs),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .mem_addr    (mem_addr),
        .mem_req     (mem_req),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .busy        (busy),
        .underrun    (underrun)
    );

    // ---------------- clock ----------------
    always #CLK_HALF clk = ~clk;

    // ---------------- memory model ----------------
    logic [7:0]  mem_arr [65536];
    logic [15:0] addr_log [$];
    logic [7:0]  exp_q [$];
    int          base_lat  = 3;
    int          stall_req = -1;
    int          req_idx   = 0;
    int          m_cnt     = 0;
    int          m_lat     = 0;
    bit          m_active  = 1'b0;
    bit          exp_underrun = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always @(negedge clk) begin
        if (rst) begin
            mem_ready = 1'b0;
            m_active  = 1'b0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
        end else if (mem_req) begin
            if (!m_active) begin
                m_active = 1'b1;
                m_cnt    = 0;
                addr_log.push_back(mem_addr);
                m_lat = (req_idx == stall_req) ? STALL_LAT : base_lat;
                req_idx++;
            end
            m_cnt++;
            if (m_cnt >= m_lat) begin
                mem_rdata = mem_arr[mem_addr];
                mem_ready = 1'b1;
                m_active  = 1'b0;
            end
        end
    end

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic spi_shift(input logic [31:0] tx, input int nbits,
                             output logic [7:0] rx, output bit oe_all, output bit oe_any);
        rx     = 8'h00;
        oe_all = 1'b1;
        oe_any = 1'b0;
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_mosi = tx[i];
            #(SCLK_HALF);
            rx     = {rx[6:0], spi_miso};
            oe_all = oe_all & spi_miso_oe;
            oe_any = oe_any | spi_miso_oe;
            spi_sclk = 1'b1;
            #(SCLK_HALF);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic txn(input logic [7:0] cmd, input logic [23:0] addr, input int nbytes,
                       input int lat, input int stall);
        logic [7:0] rx, exp_b;
        bit         oe_all, oe_any, is_read, is_stat;
        is_read = (cmd == 8'h0B);
`ifdef SPI_RESP_STATUS_EN
        is_stat = (cmd == 8'h05);
`else
        is_stat = 1'b0;
`endif
        base_lat  = lat;
        stall_req = is_read ? stall : -1;
        req_idx   = 0;
        addr_log.delete();
        exp_q.delete();
        for (int i = 0; i < nbytes; i++) begin
            if (is_read)
                exp_q.push_back((i == stall) ? 8'h00 : mem_arr[16'(addr[15:0] + 16'(i))]);
            else if (is_stat)
                exp_q.push_back({6'b0, exp_underrun, 1'b0});
        end
        if (is_read && stall >= 0 && stall < nbytes) exp_underrun = 1'b1;

        @(posedge clk);
        #3;
        spi_cs = 1'b0;
        #(SCLK_HALF);
        spi_shift({24'h0, cmd}, 8, rx, oe_all, oe_any);
        check("busy_open", busy, 1);
        if (is_read) begin
            spi_shift({8'h0, addr}, 24, rx, oe_all, oe_any);
            spi_shift($urandom, 8, rx, oe_all, oe_any);
        end
        for (int i = 0; i < nbytes; i++) begin
            spi_shift($urandom, 8, rx, oe_all, oe_any);
            if (is_read || is_stat) begin
                exp_b = exp_q.pop_front();
                check("miso_oe_data", oe_all, 1);
                check("rx_byte", rx, exp_b);
            end else begin
                check("miso_oe_ignored", oe_any, 0);
            end
        end
        #(SCLK_HALF);
        spi_cs = 1'b1;
        repeat (6) @(posedge clk);
        #3;
        check("busy_closed", busy, 0);
        check("miso_oe_closed", spi_miso_oe, 0);
        repeat ((stall >= 0) ? STALL_LAT + 60 : 40) @(posedge clk);
        #3;
        check("underrun", underrun, exp_underrun);
        if (is_read) begin
            check("req_count", addr_log.size() >= nbytes, 1);
            for (int i = 0; i < nbytes && i < addr_log.size(); i++)
                check("mem_addr", addr_log[i], 16'(addr[15:0] + 16'(i)));
        end else begin
            check("no_mem_req", addr_log.size(), 0);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- main sequence ----------------
    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          nbytes;
        int          lat;
        int          stall;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [7:0]  rx;
        bit          oe_all, oe_any;
        logic [7:0]  rcmd;
        logic [23:0] raddr;

        for (int i = 0; i < 65536; i++) mem_arr[i] = 8'($urandom);

        vecs[0] = '{8'h0B, 24'h000010, 1, 3, -1};
        vecs[1] = '{8'h0B, 24'h00FFFE, 4, 3, -1};
        vecs[2] = '{8'h9F, 24'h000000, 2, 3, -1};
        vecs[3] = '{8'h0B, 24'h000010, 2, 3, -1};
        vecs[4] = '{8'h0B, 24'hAB1234, 3, 7, -1};
        vecs[5] = '{8'h0B, 24'h000100, 2, 5, 1};
        vecs[6] = '{8'h0B, 24'h00FFFF, 3, 12, -1};

        // reset
        rst      = 1'b1;
        spi_cs   = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("rst_miso", spi_miso, 0);
        check("rst_miso_oe", spi_miso_oe, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_underrun", underrun, 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // directed table
        for (int v = 0; v < 7; v++)
            txn(vecs[v].cmd, vecs[v].addr, vecs[v].nbytes, vecs[v].lat, vecs[v].stall);

        // READ STATUS (or ignored command in the default build)
        txn(8'h05, 24'h0, 2, 3, -1);

        // abort after 13 address bits, then a clean read
        @(posedge clk);
        #3;
        addr_log.delete();
        spi_cs = 1'b0;
        #(SCLK_HALF);
        spi_shift(32'h0B, 8, rx, oe_all, oe_any);
        spi_shift(32'h1ABC, 13, rx, oe_all, oe_any);
        #(SCLK_HALF);
        spi_cs = 1'b1;
        repeat (6) @(posedge clk);
        #3;
        check("abort_busy", busy, 0);
        check("abort_miso_oe", spi_miso_oe, 0);
        repeat (20) @(posedge clk);
        check("abort_no_req", addr_log.size(), 0);
        txn(8'h0B, 24'h000040, 1, 3, -1);

        // randomized transactions
        for (int r = 0; r < 12; r++) begin
            rcmd = 8'h0B;
            if ($urandom_range(0, 3) == 0) begin
                rcmd = 8'($urandom_range(0, 255));
                if (rcmd == 8'h0B || rcmd == 8'h05) rcmd = 8'h9F;
            end
            raddr = 24'($urandom);
            txn(rcmd, raddr, $urandom_range(1, 5), $urandom_range(1, 20), -1);
        end

        // underrun is cleared only by reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        exp_underrun = 1'b0;
        check("rst2_underrun", underrun, exp_underrun);
        check("rst2_mem_req", mem_req, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
